// File: rtl/io_output_serializer_pkg.sv
// io_output_serializer_pkg: shared serializer state type and clog2 helper
// Contents:
//   ser_state_t  two-state serializer FSM encoding (IDLE / SHIFT)
//   clog2        ceiling log2, used to size the beat counter
package io_output_serializer_pkg;
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/io_output_serializer_beat_counter.sv
// io_output_serializer_beat_counter: modulo-BEATS beat counter with load-to-zero and terminal flag
// Ports:
//   clock     single clock
//   clear     asynchronous active-high reset, count -> 0
//   load      restart at beat 0 (takes priority over inc)
//   inc       advance one beat, wrapping to 0 after BEATS-1
//   count     current beat index
//   terminal  count is on the last beat (BEATS-1)
module io_output_serializer_beat_counter #(
   parameter int BEATS       = 8,
   parameter int COUNT_WIDTH = 3
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic                   load,
   input  logic                   inc,
   output logic [COUNT_WIDTH-1:0] count,
   output logic                   terminal
);
   assign terminal = count == COUNT_WIDTH'(BEATS - 1);
   always_ff @(posedge clock or posedge clear)
      if (clear) count <= '0;
      else if (load || (inc && terminal)) count <= '0;
      else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/io_output_serializer.sv
// io_output_serializer: word-to-lane serializer feeding the output I/O register bank, LSB lane first
// Ports:
//   clock            single clock
//   clear            asynchronous active-high reset
//   input_valid      upstream word available
//   input_ready      a word can be accepted this cycle (from registers only)
//   input_data       WORD_WIDTH word to serialize
//   io_data_out      current LANE_WIDTH beat, IDLE_VALUE when no word is in flight
//   io_frame_out     high on the first beat of each word
//   io_clock_enable  high while a beat is valid
module io_output_serializer
   import io_output_serializer_pkg::*;
#(
   parameter int                    WORD_WIDTH = 32,
   parameter int                    LANE_WIDTH = 4,
   parameter logic [LANE_WIDTH-1:0] IDLE_VALUE = '0
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  input_valid,
   output logic                  input_ready,
   input  logic [WORD_WIDTH-1:0] input_data,
   output logic [LANE_WIDTH-1:0] io_data_out,
   output logic                  io_frame_out,
   output logic                  io_clock_enable
);
   localparam int BEATS       = WORD_WIDTH / LANE_WIDTH;
   localparam int COUNT_WIDTH = clog2(BEATS);

   if (WORD_WIDTH % LANE_WIDTH != 0 || BEATS < 2) begin : g_bad_params
      $error("io_output_serializer: WORD_WIDTH must be a multiple of LANE_WIDTH with at least 2 beats");
   end

   ser_state_t             state, state_next;
   logic [WORD_WIDTH-1:0]  shift_reg;
   logic [COUNT_WIDTH-1:0] beat_count;
   logic                   terminal, busy, accept;

   assign busy   = state == SHIFT;
   assign accept = input_valid && input_ready;

   io_output_serializer_beat_counter #(.BEATS(BEATS), .COUNT_WIDTH(COUNT_WIDTH)) u_beat_counter (
      .clock    (clock),
      .clear    (clear),
      .load     (accept),
      .inc      (busy),
      .count    (beat_count),
      .terminal (terminal)
   );

   always_ff @(posedge clock or posedge clear)
      if (clear) state <= IDLE;
      else state <= state_next;

   // A handshake on the last beat keeps SHIFT so the next word follows with no gap.
   always_comb state_next = accept ? SHIFT : (busy && terminal) ? IDLE : state;

   always_ff @(posedge clock or posedge clear)
      if (clear) shift_reg <= '0;
      else if (accept) shift_reg <= input_data;
      else if (busy) shift_reg <= shift_reg >> LANE_WIDTH;

   always_comb begin
      input_ready     = !busy || terminal;
      io_data_out     = busy ? shift_reg[LANE_WIDTH-1:0] : IDLE_VALUE;
      io_frame_out    = busy && beat_count == '0;
      io_clock_enable = busy;
   end
endmodule

// File: tb/tb_io_output_serializer.sv
// tb_io_output_serializer: scoreboard bench for a 16/4 and an 8/1 serializer instance
module tb_io_output_serializer;
   typedef struct {logic [3:0] lane; logic frame;} beat_t;

   localparam logic [3:0] IDLE16 = 4'h9;

   logic        clock = 0, clear = 1;
   logic        valid16 = 0, ready16, frame16, en16;
   logic [15:0] data16 = '0;
   logic [3:0]  out16;
   logic        valid8 = 0, ready8, frame8, en8;
   logic [7:0]  data8 = '0;
   logic [0:0]  out8;
   int          checks = 0, failures = 0;
   beat_t       q16[$], q8[$];

   always #5 clock = ~clock;

   io_output_serializer #(.WORD_WIDTH(16), .LANE_WIDTH(4), .IDLE_VALUE(IDLE16)) dut16 (
      .clock(clock), .clear(clear), .input_valid(valid16), .input_ready(ready16),
      .input_data(data16), .io_data_out(out16), .io_frame_out(frame16), .io_clock_enable(en16));

   io_output_serializer #(.WORD_WIDTH(8), .LANE_WIDTH(1), .IDLE_VALUE(1'b0)) dut8 (
      .clock(clock), .clear(clear), .input_valid(valid8), .input_ready(ready8),
      .input_data(data8), .io_data_out(out8), .io_frame_out(frame8), .io_clock_enable(en8));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, want, $time);
      end
   endtask

   // Scoreboards: beats are queued when a handshake is seen and popped as the DUT emits them.
   always @(negedge clock) begin
      beat_t e;
      if (clear) begin
         q16.delete();
         check("rst_ready16", ready16, 1);
         check("rst_en16", en16, 0);
         check("rst_frame16", frame16, 0);
         check("rst_data16", out16, IDLE16);
      end else begin
         check("ready16", ready16, q16.size() <= 1);
         check("en16", en16, q16.size() != 0);
         if (q16.size() != 0) begin
            e = q16.pop_front();
            check("data16", out16, e.lane);
            check("frame16", frame16, e.frame);
         end else begin
            check("idle_data16", out16, IDLE16);
            check("idle_frame16", frame16, 0);
         end
         if (valid16 && ready16)
            for (int i = 0; i < 4; i++) q16.push_back('{lane: 4'((data16 >> (4 * i)) & 16'hF), frame: i == 0});
      end
   end

   always @(negedge clock) begin
      beat_t e;
      if (clear) begin
         q8.delete();
         check("rst_ready8", ready8, 1);
         check("rst_en8", en8, 0);
         check("rst_frame8", frame8, 0);
         check("rst_data8", out8, 0);
      end else begin
         check("ready8", ready8, q8.size() <= 1);
         check("en8", en8, q8.size() != 0);
         if (q8.size() != 0) begin
            e = q8.pop_front();
            check("data8", out8, e.lane);
            check("frame8", frame8, e.frame);
         end else begin
            check("idle_data8", out8, 0);
            check("idle_frame8", frame8, 0);
         end
         if (valid8 && ready8)
            for (int i = 0; i < 8; i++) q8.push_back('{lane: 4'(data8[i]), frame: i == 0});
      end
   end

   // Holds valid until the handshake edge, then drops valid just after it.
   task automatic send16(input logic [15:0] d);
      int n;
      valid16 = 1;
      data16  = d;
      for (n = 0; n < 50; n++) begin
         @(negedge clock);
         if (ready16) break;
      end
      if (n == 50) check("timeout16", 0, 1);
      @(posedge clock);
      #1 valid16 = 0;
      data16 = 16'($urandom);
   endtask

   task automatic send8(input logic [7:0] d);
      int n;
      valid8 = 1;
      data8  = d;
      for (n = 0; n < 50; n++) begin
         @(negedge clock);
         if (ready8) break;
      end
      if (n == 50) check("timeout8", 0, 1);
      @(posedge clock);
      #1 valid8 = 0;
   endtask

   task automatic drain(input int cycles);
      repeat (cycles) @(posedge clock);
      #1;
   endtask

   initial begin
      repeat (4) begin
         @(posedge clock);
         #1 valid16 = 1'($urandom);
         data16 = 16'($urandom);
         valid8 = 1'($urandom);
         data8 = 8'($urandom);
      end
      @(posedge clock);
      #1 clear = 0;
      valid16 = 0;
      valid8 = 0;
      drain(2);
      send16(16'hA5C3);
      drain(6);
      send16(16'h1234);
      send16(16'hBEEF);
      drain(6);
      send16(16'hA5C3);
      @(posedge clock);
      #1;
      send16(16'hFFFF);
      drain(6);
      send16(16'hA5C3);
      @(posedge clock);
      #2 clear = 1;
      #1 check("async_en16", en16, 0);
      check("async_data16", out16, IDLE16);
      check("async_ready16", ready16, 1);
      @(posedge clock);
      #1 clear = 0;
      drain(1);
      send16(16'h0F0F);
      drain(6);
      send8(8'h81);
      send8(8'h6C);
      drain(10);
      check("q16_empty", q16.size(), 0);
      check("q8_empty", q8.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
